i2s_recorder: RTL
=================

I2S_RECORDER -- requirements
Module: i2s_recorder

Interface
REQ-001 The block SHALL have parameter DATA_W, default 16, sample width in bits.
REQ-002 The block SHALL have parameter CNT_W, default 20, sample-counter width, matching the SRAM address width.
REQ-003 The block SHALL have parameter SYNC_STAGES, default 2, synchronizer depth for the codec inputs.
REQ-004 i_clk  in  1  system clock; its frequency SHALL be at least 4x AUD_BCLK.
REQ-005 i_rst  in  1  reset, asynchronous, active-low.
REQ-006 i_start  in  1  one-cycle pulse that begins or resumes recording.
REQ-007 i_pause  in  1  one-cycle pulse that suspends recording.
REQ-008 i_stop  in  1  one-cycle pulse that ends recording.
REQ-009 i_bclk  in  1  codec bit clock, asynchronous to i_clk.
REQ-010 i_adclrck  in  1  codec left/right clock, asynchronous; low means left channel.
REQ-011 i_adcdat  in  1  codec serial data, MSB first.
REQ-012 o_data  out  DATA_W  last captured left-channel sample, two's complement.
REQ-013 o_valid  out  1  one-cycle pulse marking a new o_data; drives the SRAM stage's in_signal_valid.
REQ-014 o_count  out  CNT_W  number of samples emitted since the last start from STOP.
REQ-015 o_full  out  1  level; high when o_count equals 2^CNT_W-1.
REQ-016 o_frame_err  out  1  one-cycle pulse when a partial frame is discarded.

Function
REQ-017 i_bclk, i_adclrck and i_adcdat SHALL each pass through SYNC_STAGES flops; a BCLK rising edge (rise) is detected when the synchronized bclk is 1 and its previous value was 0.
REQ-018 FSM states SHALL be STOP, ALIGN, SKIP, SHIFT, EMIT and PAUSE.
REQ-019 STOP: on i_start, clear o_count to 0 and go to ALIGN.
REQ-020 ALIGN: wait for a synchronized adclrck 1->0 transition, then go to SKIP.
REQ-021 SKIP: on the next rise, go to SHIFT with bit counter = 0 (I2S one-BCLK MSB delay).
REQ-022 SHIFT: on each rise, shift the synchronized adcdat into an internal shift register (MSB first) and increment the bit counter; after DATA_W bits, go to EMIT.
REQ-023 EMIT: for one cycle, load o_data, pulse o_valid, increment o_count (saturating at 2^CNT_W-1), then go to ALIGN.
REQ-024 Latency: o_valid SHALL be asserted exactly 2 i_clk cycles after the cycle in which the rise capturing the LSB is detected.
REQ-025 Right-channel bits (adclrck high) SHALL be ignored; only left samples are emitted.
REQ-026 If adclrck goes high while in SHIFT before DATA_W bits are captured: discard the partial sample, pulse o_frame_err, go to ALIGN, and leave o_count unchanged.
REQ-027 In any recording state, i_pause SHALL take the FSM to PAUSE, discarding any partial sample without raising o_frame_err; o_count is held.
REQ-028 PAUSE: on i_start, go to ALIGN with o_count retained.
REQ-029 i_stop in any state SHALL go to STOP, discarding any partial sample; o_count and o_data are held until the next i_start.
REQ-030 When o_full is high, the FSM SHALL go to STOP after the EMIT cycle; no further o_valid pulses are issued until i_start.
REQ-031 Priority of simultaneous pulses SHALL be i_stop > i_pause > i_start.
REQ-032 An i_stop in the EMIT cycle SHALL still complete that emit, then go to STOP.
REQ-033 o_data SHALL change only in EMIT.

Reset
REQ-034 Asserting i_rst low SHALL immediately force state STOP, o_data=0, o_valid=0, o_count=0, o_full=0, o_frame_err=0, bit counter=0, shift register=0, and all synchronizer flops to 0.
REQ-035 Reset asserted mid-frame SHALL emit no o_valid on release.
REQ-036 After reset release, the block SHALL remain in STOP until i_start.

Structure
REQ-037 The state enum, DATA_W and CNT_W defaults SHALL reside in a shared package audio_pkg, also used by the SRAM stage.
REQ-038 One sub-module, sync_edge, SHALL provide the synchronizer chain plus rise/fall detection; it is instantiated for bclk and adclrck.
REQ-039 adcdat SHALL use a plain synchronizer of equal depth so that it stays aligned with the bclk edges.

Verification
REQ-040 Start, one left frame 16'hA5C3 -> o_valid pulses once, o_data=16'hA5C3, o_count=1.
REQ-041 10 consecutive frames (left 16'h8000+n, right 16'hFFFF) -> 10 pulses, data 8000..8009 in order, right-channel data never appears.
REQ-042 adclrck rises after 9 left bits -> o_frame_err pulse, no o_valid, o_count unchanged; next full frame is captured correctly.
REQ-043 Pause mid-frame, resume with i_start, one frame 16'h1234 -> exactly one pulse, o_data=16'h1234, o_count=previous value+1.
REQ-044 CNT_W=4, 16 frames -> o_full high at o_count=15, the 16th frame is not emitted, FSM is in STOP.
REQ-045 i_rst low during bit 7 of a frame, then release -> all outputs 0, no o_valid until i_start followed by a full frame.

Source files
------------

// File: rtl/audio_pkg.sv
// Shared audio definitions for the I2S recorder and the SRAM stage behind it.
// Holds the recorder state encoding and the default sample/counter widths.
package audio_pkg;

  localparam int DEF_DATA_W      = 16;
  localparam int DEF_CNT_W       = 20;
  localparam int DEF_SYNC_STAGES = 2;

  typedef enum logic [2:0] {
    STOP  = 3'd0,
    ALIGN = 3'd1,
    SKIP  = 3'd2,
    SHIFT = 3'd3,
    EMIT  = 3'd4,
    PAUSE = 3'd5
  } rec_state_t;

endpackage

// File: rtl/sync_edge.sv
// Multi-flop synchronizer for one asynchronous codec line, plus rise/fall
// strobes derived from the synchronized value.
module sync_edge #(
  parameter int STAGES = 2
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic d,
  output logic q,
  output logic rise,
  output logic fall
);

  logic [STAGES-1:0] chain;
  logic              prev;

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      chain <= '0;
      prev  <= 1'b0;
    end else begin
      chain[0] <= d;
      for (int i = 1; i < STAGES; i++) chain[i] <= chain[i-1];
      prev <= chain[STAGES-1];
    end
  end

  assign q    = chain[STAGES-1];
  assign rise = q & ~prev;
  assign fall = ~q & prev;

endmodule

// File: rtl/i2s_recorder.sv
// I2S left-channel recorder: captures DATA_W-bit left samples from a codec
// and hands each one to the SRAM stage as a single-cycle valid pulse.
module i2s_recorder
  import audio_pkg::*;
#(
  parameter int DATA_W      = DEF_DATA_W,
  parameter int CNT_W       = DEF_CNT_W,
  parameter int SYNC_STAGES = DEF_SYNC_STAGES
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_start,
  input  logic              i_pause,
  input  logic              i_stop,
  input  logic              i_bclk,
  input  logic              i_adclrck,
  input  logic              i_adcdat,
  output logic [DATA_W-1:0] o_data,
  output logic              o_valid,
  output logic [CNT_W-1:0]  o_count,
  output logic              o_full,
  output logic              o_frame_err
);

  localparam int               BIT_W    = $clog2(DATA_W + 1);
  localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(DATA_W - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  rec_state_t        state;
  logic [BIT_W-1:0]  bit_cnt;
  logic [DATA_W-1:0] shreg;
  logic [CNT_W-1:0]  cnt_inc;

  logic bclk_q, bclk_rise, bclk_fall;
  logic lrck_q, lrck_rise, lrck_fall;
  logic [SYNC_STAGES-1:0] dat_sync;
  logic dat_s;
  logic unused_edges;

  sync_edge #(.STAGES(SYNC_STAGES)) u_bclk (
    .i_clk (i_clk),
    .i_rst (i_rst),
    .d     (i_bclk),
    .q     (bclk_q),
    .rise  (bclk_rise),
    .fall  (bclk_fall)
  );

  sync_edge #(.STAGES(SYNC_STAGES)) u_lrck (
    .i_clk (i_clk),
    .i_rst (i_rst),
    .d     (i_adclrck),
    .q     (lrck_q),
    .rise  (lrck_rise),
    .fall  (lrck_fall)
  );

  // Same depth as the bclk chain so a detected rise sees the bit it latched.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      dat_sync <= '0;
    end else begin
      dat_sync[0] <= i_adcdat;
      for (int i = 1; i < SYNC_STAGES; i++) dat_sync[i] <= dat_sync[i-1];
    end
  end

  assign dat_s        = dat_sync[SYNC_STAGES-1];
  assign unused_edges = &{1'b0, bclk_q, bclk_fall, lrck_rise};

  // Control pulses resolved by priority: stop > pause > start.
  logic go_stop, go_pause, go_start;
  assign go_stop  = i_stop;
  assign go_pause = i_pause & ~i_stop;
  assign go_start = i_start & ~i_pause & ~i_stop;

  assign cnt_inc = (o_count == CNT_MAX) ? o_count : o_count + 1'b1;

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      state       <= STOP;
      bit_cnt     <= '0;
      shreg       <= '0;
      o_data      <= '0;
      o_valid     <= 1'b0;
      o_count     <= '0;
      o_full      <= 1'b0;
      o_frame_err <= 1'b0;
    end else begin
      o_valid     <= 1'b0;
      o_frame_err <= 1'b0;
      case (state)
        STOP: begin
          if (go_start) begin
            o_count <= '0;
            o_full  <= 1'b0;
            state   <= ALIGN;
          end
        end
        PAUSE: begin
          if (go_stop)       state <= STOP;
          else if (go_start) state <= ALIGN;
        end
        ALIGN: begin
          if (go_stop)        state <= STOP;
          else if (go_pause)  state <= PAUSE;
          else if (lrck_fall) state <= SKIP;
        end
        SKIP: begin
          if (go_stop)       state <= STOP;
          else if (go_pause) state <= PAUSE;
          else if (bclk_rise) begin
            bit_cnt <= '0;
            state   <= SHIFT;
          end
        end
        SHIFT: begin
          // The LSB slot may legitimately sit under a high lrck when the
          // codec packs exactly DATA_W clocks per channel.
          if (go_stop)       state <= STOP;
          else if (go_pause) state <= PAUSE;
          else if (lrck_q && bit_cnt < LAST_BIT) begin
            o_frame_err <= 1'b1;
            state       <= ALIGN;
          end else if (bclk_rise) begin
            shreg   <= {shreg[DATA_W-2:0], dat_s};
            bit_cnt <= bit_cnt + 1'b1;
            if (bit_cnt == LAST_BIT) state <= EMIT;
          end
        end
        EMIT: begin
          o_data  <= shreg;
          o_valid <= 1'b1;
          o_count <= cnt_inc;
          o_full  <= (cnt_inc == CNT_MAX);
          if (go_stop || cnt_inc == CNT_MAX) state <= STOP;
          else if (go_pause)                 state <= PAUSE;
          else                               state <= ALIGN;
        end
        default: state <= STOP;
      endcase
    end
  end

endmodule
